vram_fetch_arbiter: RTL and testbench

// - Shares one single-port VRAM (32b words, 2 glyph cells per word) between the AXI host side and the display path.
// - Prefetches the next 16-px cell word ahead of the beam and presents it on cp_word to the colour mapper.
// - Host gets every cycle the display path does not need; display always wins a conflict.
// - Sits between the AXI slave register logic, the VRAM BRAM and the colour mapper, in the single axi_aclk domain.

---
 rtl/vram_fetch_arbiter_if.sv | 24 ++
 rtl/vram_fetch_arbiter.sv | 152 +++++++++++++++
 tb/tb_vram_fetch_arbiter.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/vram_fetch_arbiter_if.sv
// Host-side access port of the VRAM fetch arbiter: a held request/grant
// handshake plus a read-return pulse.
interface vram_fetch_arbiter_if #(
  parameter int ADDR_W = 11
);
  logic              host_req;
  logic              host_we;
  logic [ADDR_W-1:0] host_addr;
  logic [31:0]       host_wdata;
  logic [3:0]        host_wstrb;
  logic              host_gnt;
  logic              host_rvalid;
  logic [31:0]       host_rdata;

  modport master (
    output host_req, host_we, host_addr, host_wdata, host_wstrb,
    input  host_gnt, host_rvalid, host_rdata
  );

  modport slave (
    input  host_req, host_we, host_addr, host_wdata, host_wstrb,
    output host_gnt, host_rvalid, host_rdata
  );
endinterface

// File: rtl/vram_fetch_arbiter.sv
// Shares one single-port VRAM between the host and the text-mode display prefetch.
// Optional VRAM_ARB_STATS_EN adds host stall and display fetch counters.
module vram_fetch_arbiter #(
  parameter int ADDR_W   = 11,
  parameter int COLS     = 40,
  parameter int H_ACTIVE = 640,
  parameter int H_TOTAL  = 800,
  parameter int V_ACTIVE = 480,
  parameter int V_TOTAL  = 525
) (
  input  logic               axi_aclk,
  input  logic               axi_aresetn,
  input  logic [9:0]         drawx,
  input  logic [9:0]         drawy,
  vram_fetch_arbiter_if.slave host,
  output logic               vram_en,
  output logic [3:0]         vram_we,
  output logic [ADDR_W-1:0]  vram_addr,
  output logic [31:0]        vram_din,
  input  logic [31:0]        vram_dout,
  output logic [31:0]        cp_word,
  output logic               underrun
`ifdef VRAM_ARB_STATS_EN
  ,
  output logic [15:0]        host_stall_cnt,
  output logic [15:0]        fetch_cnt
`endif
);

  typedef enum logic [2:0] {IDLE, D_RD, D_CAP, H_WR, H_RD, H_CAP} state_t;

  state_t            state;
  logic [9:0]        drawx_q;
  logic              disp_pend;
  logic [ADDR_W-1:0] disp_addr;
  logic [31:0]       next_word;
  logic              next_ok;

  logic              step, trig_a, trig_b, trig, bnd;
  logic [9:0]        ny;
  logic [ADDR_W-1:0] a_addr, b_addr, trig_addr;

  always_comb begin
    step      = (drawx != drawx_q);
    ny        = (drawy == 10'(V_TOTAL - 1)) ? 10'd0 : drawy + 10'd1;
    a_addr    = ADDR_W'(drawx[9:4]) + ADDR_W'(1) + ADDR_W'(drawy[9:4]) * ADDR_W'(COLS);
    b_addr    = ADDR_W'(ny[9:4]) * ADDR_W'(COLS);
    trig_a    = step && (drawx[3:0] == 4'd8) && (drawx < 10'(H_ACTIVE - 16));
    trig_b    = step && (drawx == 10'(H_TOTAL - 8)) && (ny < 10'(V_ACTIVE));
    trig      = trig_a || trig_b;
    trig_addr = trig_a ? a_addr : b_addr;
    bnd       = step && (drawx[3:0] == 4'd0) && (drawx < 10'(H_ACTIVE));
  end

  // Port outputs are registered on entry to the state that owns the port,
  // so every strobe defaults low and is raised only by the transition.
  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      state            <= IDLE;
      drawx_q          <= '0;
      disp_pend        <= 1'b0;
      disp_addr        <= '0;
      next_word        <= '0;
      next_ok          <= 1'b0;
      cp_word          <= '0;
      underrun         <= 1'b0;
      vram_en          <= 1'b0;
      vram_we          <= '0;
      vram_addr        <= '0;
      vram_din         <= '0;
      host.host_gnt    <= 1'b0;
      host.host_rvalid <= 1'b0;
      host.host_rdata  <= '0;
    end else begin
      drawx_q          <= drawx;
      vram_en          <= 1'b0;
      vram_we          <= '0;
      host.host_gnt    <= 1'b0;
      host.host_rvalid <= 1'b0;

      // A pending fetch already issued in D_RD is not a lost one.
      if (trig) begin
        disp_pend <= 1'b1;
        disp_addr <= trig_addr;
        if (disp_pend && state != D_RD) underrun <= 1'b1;
      end

      if (bnd) begin
        if (next_ok) begin
          cp_word <= next_word;
          next_ok <= 1'b0;
        end else begin
          underrun <= 1'b1;
        end
      end

      case (state)
        IDLE: begin
          // A trigger seen this very cycle outranks a waiting host request.
          if (disp_pend || trig) begin
            state     <= D_RD;
            vram_en   <= 1'b1;
            vram_addr <= trig ? trig_addr : disp_addr;
          end else if (host.host_req) begin
            vram_en       <= 1'b1;
            vram_addr     <= host.host_addr;
            host.host_gnt <= 1'b1;
            if (host.host_we) begin
              vram_we  <= host.host_wstrb;
              vram_din <= host.host_wdata;
              state    <= H_WR;
            end else begin
              state    <= H_RD;
            end
          end
        end
        D_RD: begin
          if (!trig) disp_pend <= 1'b0;
          state <= D_CAP;
        end
        D_CAP: begin
          next_word <= vram_dout;
          next_ok   <= 1'b1;
          state     <= IDLE;
        end
        H_WR: state <= IDLE;
        H_RD: state <= H_CAP;
        H_CAP: begin
          host.host_rdata  <= vram_dout;
          host.host_rvalid <= 1'b1;
          state            <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef VRAM_ARB_STATS_EN
  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      host_stall_cnt <= '0;
      fetch_cnt      <= '0;
    end else begin
      if (host.host_req && !host.host_gnt && host_stall_cnt != 16'hFFFF)
        host_stall_cnt <= host_stall_cnt + 16'd1;
      if (state == D_CAP)
        fetch_cnt <= fetch_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_vram_fetch_arbiter.sv
// Directed bench for vram_fetch_arbiter with a 1-cycle-latency byte-write BRAM model.
module tb_vram_fetch_arbiter;

  localparam int ADDR_W = 11;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [9:0]        drawx, drawy;
  logic              vram_en;
  logic [3:0]        vram_we;
  logic [ADDR_W-1:0] vram_addr;
  logic [31:0]       vram_din, vram_dout, cp_word;
  logic              underrun;
`ifdef VRAM_ARB_STATS_EN
  logic [15:0]       host_stall_cnt, fetch_cnt;
`endif

  int n_cmp = 0;
  int n_err = 0;

  vram_fetch_arbiter_if #(.ADDR_W(ADDR_W)) hif ();

  vram_fetch_arbiter #(.ADDR_W(ADDR_W)) dut (
    .axi_aclk    (clk),
    .axi_aresetn (rst_n),
    .drawx       (drawx),
    .drawy       (drawy),
    .host        (hif),
    .vram_en     (vram_en),
    .vram_we     (vram_we),
    .vram_addr   (vram_addr),
    .vram_din    (vram_din),
    .vram_dout   (vram_dout),
    .cp_word     (cp_word),
    .underrun    (underrun)
`ifdef VRAM_ARB_STATS_EN
    ,
    .host_stall_cnt (host_stall_cnt),
    .fetch_cnt      (fetch_cnt)
`endif
  );

  always #5 clk = ~clk;

  // BRAM: word i preloads to 5A000000|i on the first edge (port idle in reset).
  logic [31:0] mem [0:2047];
  logic        loaded = 1'b0;
  always @(posedge clk) begin
    if (!loaded) begin
      for (int i = 0; i < 2048; i++) mem[i] <= 32'h5A00_0000 | 32'(i);
      loaded <= 1'b1;
    end else if (vram_en) begin
      for (int b = 0; b < 4; b++)
        if (vram_we[b]) mem[vram_addr][8*b +: 8] <= vram_din[8*b +: 8];
      vram_dout <= mem[vram_addr];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue a host op and wait (bounded) for its grant; read data is checked by the caller.
  task automatic host_op(input logic we, input logic [ADDR_W-1:0] a,
                         input logic [31:0] d, input logic [3:0] s, input string tag);
    bit got = 0;
    hif.host_req = 1'b1; hif.host_we = we; hif.host_addr = a;
    hif.host_wdata = d;  hif.host_wstrb = s;
    for (int i = 0; i < 20 && !got; i++) begin
      tick();
      got = hif.host_gnt;
    end
    hif.host_req = 1'b0;
    chk({tag, "_gnt"}, {31'b0, got}, 32'd1);
  endtask

  task automatic host_read(input logic [ADDR_W-1:0] a, input logic [31:0] exp, input string tag);
    host_op(1'b0, a, 32'h0, 4'h0, tag);
    tick();
    chk({tag, "_rvalid_early"}, {31'b0, hif.host_rvalid}, 32'd0);
    tick();
    chk({tag, "_rvalid"}, {31'b0, hif.host_rvalid}, 32'd1);
    chk({tag, "_rdata"}, hif.host_rdata, exp);
  endtask

  initial begin
    rst_n = 1'b0;
    drawx = '0; drawy = '0;
    hif.host_req = 1'b1; hif.host_we = 1'b1; hif.host_addr = 11'd5;
    hif.host_wdata = 32'hA1B2_C3D4; hif.host_wstrb = 4'hF;

    // Reset held with a write request pending: nothing moves.
    repeat (3) tick();
    chk("rst_gnt", {31'b0, hif.host_gnt}, 32'd0);
    chk("rst_en", {31'b0, vram_en}, 32'd0);
    chk("rst_cp", cp_word, 32'd0);
    chk("rst_underrun", {31'b0, underrun}, 32'd0);
    chk("rst_rvalid", {31'b0, hif.host_rvalid}, 32'd0);

    // Release away from the edge; the first edge out of reset grants the write.
    rst_n = 1'b1;
    tick();
    chk("wr5_gnt", {31'b0, hif.host_gnt}, 32'd1);
    chk("wr5_we", {28'b0, vram_we}, 32'hF);
    chk("wr5_addr", {21'b0, vram_addr}, 32'd5);
    chk("wr5_din", vram_din, 32'hA1B2_C3D4);
    hif.host_req = 1'b0;
    tick();
    chk("wr5_gnt_pulse", {31'b0, hif.host_gnt}, 32'd0);

    host_read(11'd5, 32'hA1B2_C3D4, "rd5");

    // Byte strobe: only byte 1 of an all-ones write lands.
    host_op(1'b1, 11'd7, 32'h0, 4'hF, "wr7a");
    tick();
    host_op(1'b1, 11'd7, 32'hFFFF_FFFF, 4'b0010, "wr7b");
    tick();
    host_read(11'd7, 32'h0000_FF00, "rd7");

    // Prefetch on row 1: drawx=8 fetches word 1+1*40=41, shown from drawx=16;
    // drawx=24 fetches word 42.
    drawy = 10'd16;
    for (int x = 1; x < 32; x++) begin
      drawx = 10'(x);
      tick();
      if (x == 8) begin
        chk("pf_en", {31'b0, vram_en}, 32'd1);
        chk("pf_addr", {21'b0, vram_addr}, 32'd41);
      end
      if (x == 15) chk("pf_cp_before", cp_word, 32'd0);
      if (x == 16) chk("pf_cp", cp_word, 32'h5A00_0029);
      if (x == 24) chk("pf_addr2", {21'b0, vram_addr}, 32'd42);
    end
    chk("pf_underrun", {31'b0, underrun}, 32'd0);

    // Conflict: row 2, boundary at 0 consumes word 42, then a host read lands
    // in the same cycle as the drawx=8 trigger (word 1+2*40=81). The display
    // fetch goes first; the host is granted on the 4th edge after the trigger.
    drawy = 10'd32; drawx = 10'd0;
    tick();
    chk("cf_cp42", cp_word, 32'h5A00_002A);
    drawx = 10'd8;
    hif.host_req = 1'b1; hif.host_we = 1'b0; hif.host_addr = 11'd5;
    tick();
    chk("cf_drd_addr", {21'b0, vram_addr}, 32'd81);
    chk("cf_drd_nognt", {31'b0, hif.host_gnt}, 32'd0);
    tick();
    chk("cf_dcap_nognt", {31'b0, hif.host_gnt}, 32'd0);
    tick();
    chk("cf_idle_nognt", {31'b0, hif.host_gnt}, 32'd0);
    tick();
    chk("cf_gnt", {31'b0, hif.host_gnt}, 32'd1);
    chk("cf_gnt_addr", {21'b0, vram_addr}, 32'd5);
    hif.host_req = 1'b0;
    tick();
    tick();
    chk("cf_rvalid", {31'b0, hif.host_rvalid}, 32'd1);
    chk("cf_rdata", hif.host_rdata, 32'hA1B2_C3D4);
    drawx = 10'd16;
    tick();
    chk("cf_cp81", cp_word, 32'h5A00_0051);
    chk("cf_underrun", {31'b0, underrun}, 32'd0);

    // Line 479 end: next line is blanking, no fetch.
    drawy = 10'd479; drawx = 10'd792;
    tick();
    chk("blank_no_fetch", {31'b0, vram_en}, 32'd0);
    tick();
    chk("blank_no_fetch2", {31'b0, vram_en}, 32'd0);

    // Line 524 end wraps to line 0: fetch word 0, shown at drawx=0 of line 0.
    drawy = 10'd524; drawx = 10'd791;
    tick();
    drawx = 10'd792;
    tick();
    chk("wrap_en", {31'b0, vram_en}, 32'd1);
    chk("wrap_addr", {21'b0, vram_addr}, 32'd0);
    tick();
    tick();
    drawy = 10'd0; drawx = 10'd0;
    tick();
    chk("wrap_cp", cp_word, 32'h5A00_0000);
    chk("wrap_underrun", {31'b0, underrun}, 32'd0);

    // Boundary at drawx=16 with nothing prefetched: stale word kept, sticky underrun.
    drawx = 10'd16;
    tick();
    chk("ur_set", {31'b0, underrun}, 32'd1);
    chk("ur_cp_stale", cp_word, 32'h5A00_0000);
    repeat (3) tick();
    chk("ur_sticky", {31'b0, underrun}, 32'd1);
    chk("rdata_hold", hif.host_rdata, 32'hA1B2_C3D4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
